// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with a registered grant index, a valid flag and an optional hold-time limit.
// The grant index is held between grants, so the downstream one-hot decoder does not glitch.
module rr_arbiter_8 #(
   parameter int unsigned HOLD_LIMIT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] req_i,
   input  logic       release_i,
   output logic [2:0] grant_idx_o,
   output logic       grant_valid_o,
   output logic       hold_expired_o
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state;
   logic [2:0] last;
   logic [7:0] hold_cnt;
   logic [2:0] win;
   logic       found;
   // Scan from last+1 upward; the 3-bit add wraps, so i=8 revisits last itself.
   always_comb begin
      win = last;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (!found && req_i[last + 3'(i)]) begin
            win = last + 3'(i);
            found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         last <= 3'd7;
         hold_cnt <= 8'd0;
         grant_idx_o <= 3'd0;
         grant_valid_o <= 1'b0;
         hold_expired_o <= 1'b0;
      end else begin
         hold_expired_o <= 1'b0;
         if (state == IDLE) begin
            if (|req_i) begin
               state <= GRANT;
               grant_valid_o <= 1'b1;
               grant_idx_o <= win;
               last <= win;
               hold_cnt <= 8'd0;
            end
         end else if (release_i || !req_i[grant_idx_o]) begin
            state <= IDLE;
            grant_valid_o <= 1'b0;
         end else if (HOLD_LIMIT != 0 && hold_cnt == 8'(HOLD_LIMIT - 1)) begin
            state <= IDLE;
            grant_valid_o <= 1'b0;
            hold_expired_o <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed vector table plus hand-written sequences for async reset and hold-limit expiry.
module tb_rr_arbiter_8;
   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] req_i;
   logic       release_i;
   logic [2:0] grant_idx_o;
   logic       grant_valid_o;
   logic       hold_expired_o;
   int         errors = 0;
   int         checks = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       rel;
      logic       v;
      logic [2:0] idx;
      logic       ex;
   } vec_t;
   vec_t vecs[$];

   rr_arbiter_8 #(.HOLD_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .release_i(release_i),
      .grant_idx_o(grant_idx_o), .grant_valid_o(grant_valid_o), .hold_expired_o(hold_expired_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic v, input logic [2:0] idx, input logic ex);
      chk({nm, " valid"}, {7'd0, grant_valid_o}, {7'd0, v});
      chk({nm, " idx"}, {5'd0, grant_idx_o}, {5'd0, idx});
      chk({nm, " expired"}, {7'd0, hold_expired_o}, {7'd0, ex});
   endtask

   task automatic add(input logic rst, input logic [7:0] req, input logic rel,
                      input logic v, input logic [2:0] idx, input logic ex);
      vec_t t;
      t.rst = rst; t.req = req; t.rel = rel; t.v = v; t.idx = idx; t.ex = ex;
      vecs.push_back(t);
   endtask

   initial begin
      // single requester from reset (pointer 7 -> requester 0 first)
      add(0, 8'h01, 0, 1, 3'd0, 0);
      add(0, 8'h01, 1, 0, 3'd0, 0);
      add(0, 8'h00, 0, 0, 3'd0, 0);
      // reset, then full rotation with release on the 2nd grant cycle
      add(1, 8'hFF, 0, 0, 3'd0, 0);
      for (int k = 0; k < 9; k++) begin
         add(0, 8'hFF, 0, 1, 3'(k), 0);
         add(0, 8'hFF, 0, 1, 3'(k), 0);
         add(0, 8'hFF, 1, 0, 3'(k), 0);
      end
      // wrap search: winner 5, then 8'h24 -> 2, then 5
      add(0, 8'h20, 0, 1, 3'd5, 0);
      add(0, 8'h20, 1, 0, 3'd5, 0);
      add(0, 8'h24, 0, 1, 3'd2, 0);
      add(0, 8'h24, 1, 0, 3'd2, 0);
      add(0, 8'h24, 0, 1, 3'd5, 0);
      add(0, 8'h24, 1, 0, 3'd5, 0);
      // request drop by owner 6 while requester 1 waits
      add(0, 8'h40, 0, 1, 3'd6, 0);
      add(0, 8'h02, 0, 0, 3'd6, 0);
      add(0, 8'h02, 0, 1, 3'd1, 0);
      add(0, 8'h00, 0, 0, 3'd1, 0);
      // release while idle is ignored
      add(0, 8'h00, 1, 0, 3'd1, 0);

      rst_i = 1'b1; req_i = 8'h00; release_i = 1'b0;
      #2;
      chk_out("reset", 0, 3'd0, 0);
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         rst_i = vecs[i].rst; req_i = vecs[i].req; release_i = vecs[i].rel;
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].ex);
      end
      rst_i = 1'b0;

      // async reset mid-grant, no clock edge
      req_i = 8'hFF; release_i = 1'b0;
      tick();
      chk_out("pre_rst grant", 1, 3'd2, 0);
      #2 rst_i = 1'b1;
      #1;
      chk_out("async_rst", 0, 3'd0, 0);
      tick();
      rst_i = 1'b0;
      tick();
      chk_out("post_rst grant", 1, 3'd0, 0);

      // hold limit 4 with requester 3 held
      rst_i = 1'b1; req_i = 8'h00;
      tick();
      rst_i = 1'b0; req_i = 8'h08;
      tick();
      chk_out("hold c1", 1, 3'd3, 0);
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk_out($sformatf("hold c%0d", c), 1, 3'd3, 0);
      end
      tick();
      chk_out("hold expire", 0, 3'd3, 1);
      tick();
      chk_out("hold regrant", 1, 3'd3, 0);
      req_i = 8'h00;
      tick();
      chk_out("hold drop", 0, 3'd3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter.
- Produces a registered 3-bit grant index plus a valid flag.
- The index drives the existing 3-to-8 one-hot decoder directly downstream, which generates per-requester grant lines.
- Holds a grant until release, request drop, or an optional hold-time limit; priority then rotates past the last winner.

Parameters:
- HOLD_LIMIT, 16, max consecutive cycles a grant may be held; 0 = unlimited; legal range 0..255.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  8  request vector; bit n = requester n.
- release_i  input  1  current owner finished; sampled only while grant_valid_o=1.
- grant_idx_o  output  3  index of current/last winner; feeds decoder data_i.
- grant_valid_o  output  1  grant_idx_o names an active owner.
- hold_expired_o  output  1  one-cycle pulse when a grant is revoked by HOLD_LIMIT.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high; asserting rst_i clears all state immediately, with no clock needed.
- Reset values:
  - grant_idx_o=0, grant_valid_o=0, hold_expired_o=0.
  - Internal last-winner pointer=7, so requester 0 has first priority.
  - State=IDLE, hold counter (8 bit)=0.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req_i!=0 at a clock edge, pick the first set bit searching (last+1) mod 8 upward with wrap to 0.
  - Next cycle: grant_valid_o=1, grant_idx_o=winner, last=winner, hold counter=0, state=GRANT.
  - Latency from req sample to grant: 1 cycle.
  - If req_i==0, stay in IDLE; grant_idx_o keeps its previous value.
- GRANT: at each edge, evaluate the end conditions in this order.
  - (a) release_i=1, or (b) req_i[grant_idx_o]=0: go to IDLE, grant_valid_o=0.
  - (c) HOLD_LIMIT!=0 and hold counter==HOLD_LIMIT-1: go to IDLE, grant_valid_o=0, hold_expired_o=1 for one cycle.
  - Otherwise stay in GRANT and increment the hold counter.
- grant_valid_o is high for at most HOLD_LIMIT cycles per grant.
- Mandatory one-cycle gap (grant_valid_o=0) between any two grants; arbitration for the next grant happens during that IDLE cycle.
- grant_idx_o changes only on entry to GRANT. It is stable for the whole grant and retains its value while invalid, so the decoder output is glitch-free between grants.
- Fairness:
  - The pointer updates only on grant.
  - A requester that re-asserts immediately after its own release is considered last. Every other active requester is served before it again.
  - No starvation: with HOLD_LIMIT!=0, any requester held high is granted within 8*(HOLD_LIMIT+1) cycles.
- Simultaneous release_i and req_i change in the same cycle: release wins; the new req_i is arbitrated in the following IDLE cycle.
- release_i while IDLE: ignored.
- X/unknown on req_i bits: not supported; the bench drives 0/1 only.
- Reset mid-grant: grant_valid_o drops asynchronously and the pointer returns to 7; post-reset arbitration restarts from requester 0.

Test Plan:
- Reset: assert rst_i mid-cycle with req_i=8'hFF -> grant_idx_o=0, grant_valid_o=0, hold_expired_o=0 immediately, no clock edge needed.
- Single requester: after reset, req_i=8'h01 -> one cycle later grant_valid_o=1, grant_idx_o=0. Then pulse release_i -> grant_valid_o=0 next cycle, grant_idx_o stays 0.
- Full rotation: req_i=8'hFF held, release_i pulsed on the 2nd cycle of each grant -> grant_idx_o sequence 0,1,2,3,4,5,6,7,0, with one invalid cycle between grants.
- Wrap search: last winner=5, req_i=8'h24 -> next grant_idx_o=2 (search order 6,7,0,1,2). Release -> next grant 5.
- Hold limit: HOLD_LIMIT=4, req_i=8'h08 held, release_i=0 -> grant_valid_o high exactly 4 cycles, hold_expired_o pulses once, 1 invalid cycle, then regrant to index 3.
- Request drop: granted requester 6 deasserts req_i[6] with release_i=0, req_i[1]=1 -> grant_valid_o=0 next cycle, then grant_idx_o=1. hold_expired_o stays 0.
